// File: rtl/bs_pkg.sv
// Shared definitions for the backscatter modulation controller: FSM states,
// default parameter values and width helpers.
package bs_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_QUAL  = 3'd1,
      S_DLY   = 3'd2,
      S_MOD   = 3'd3,
      S_GUARD = 3'd4
   } bs_state_e;

   localparam int DEF_N_CH     = 4;
   localparam int DEF_MIN_HIGH = 8;
   localparam int DEF_DELAY    = 16;
   localparam int DEF_MOD_LEN  = 64;
   localparam int DEF_HALF_PER = 4;

   // Bits needed to hold 0..v-1, never less than one bit.
   function automatic int bs_width(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   function automatic int bs_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bs_sqwave.sv
// Square-wave generator: starts high on the cycle after run rises, inverts
// every HALF_PER cycles while run stays high, and sits low otherwise.
module bs_sqwave
   import bs_pkg::*;
#(
   parameter int HALF_PER = DEF_HALF_PER
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sq
);

   localparam int CW = bs_width(HALF_PER);

   logic          r_run_d;
   logic          r_sq;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_d <= 1'b0;
         r_sq    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_run_d <= run;
         if (run && !r_run_d) begin
            r_sq  <= 1'b1;
            r_cnt <= '0;
         end else if (run) begin
            if (r_cnt == CW'(HALF_PER - 1)) begin
               r_sq  <= ~r_sq;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_sq  <= 1'b0;
            r_cnt <= '0;
         end
      end
   end

   assign sq = r_sq;

endmodule

// File: rtl/bs_mod_ctrl.sv
// Backscatter modulation controller: qualifies envelope-detector packets,
// waits a fixed delay, then drives one antenna select and an RF switch pair.
module bs_mod_ctrl
   import bs_pkg::*;
#(
   parameter int N_CH     = DEF_N_CH,
   parameter int MIN_HIGH = DEF_MIN_HIGH,
   parameter int DELAY    = DEF_DELAY,
   parameter int MOD_LEN  = DEF_MOD_LEN,
   parameter int HALF_PER = DEF_HALF_PER,
   localparam int CH_W    = bs_width(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_pulse,
   input  logic            mode_pulse,
   input  logic            dect_in,
   output logic            dect_out,
   output logic            en,
   output logic            busy,
   output logic [CH_W-1:0] ch_idx,
   output logic [N_CH-1:0] asw_sel,
   output logic            rfsw_a,
   output logic            rfsw_b,
   output logic [2:0]      dbg_state
);

   localparam int CNT_W = bs_width(bs_max3(MIN_HIGH, DELAY, MOD_LEN));

   logic             r_sync1;
   logic             r_sync2;
   logic             r_en;
   logic             r_rr;
   logic             r_dect_out;
   logic [CH_W-1:0]  r_ch_idx;
   logic [CNT_W-1:0] r_cnt;
   bs_state_e        r_state;

   bs_state_e        w_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_qual;
   logic             w_wrap;
   logic             w_dis;
   logic             w_run;
   logic             w_sq;

   // A disable pulse acts on the same edge that clears en, so it also beats
   // a qualification or window end landing in that cycle.
   assign w_dis = r_en & en_pulse;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_qual     = 1'b0;
      w_wrap     = 1'b0;
      if (r_state != S_IDLE && w_dis) begin
         w_next     = S_IDLE;
         w_cnt_next = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_en && r_sync2 && !w_dis) begin
                  w_next     = S_QUAL;
                  w_cnt_next = CNT_W'(1);
               end
            end
            S_QUAL: begin
               if (!r_sync2) begin
                  w_next     = S_IDLE;
                  w_cnt_next = '0;
               end else if (r_cnt >= CNT_W'(MIN_HIGH - 1)) begin
                  w_qual     = 1'b1;
                  w_next     = (DELAY == 0) ? S_MOD : S_DLY;
                  w_cnt_next = '0;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
            S_DLY: begin
               if (r_cnt >= CNT_W'(DELAY - 1)) begin
                  w_next     = S_MOD;
                  w_cnt_next = '0;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
            S_MOD: begin
               if (r_cnt >= CNT_W'(MOD_LEN - 1)) begin
                  w_next     = S_GUARD;
                  w_cnt_next = '0;
                  w_wrap     = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
            S_GUARD: begin
               if (!r_sync2) w_next = S_IDLE;
            end
            default: begin
               w_next     = S_IDLE;
               w_cnt_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_en       <= 1'b0;
         r_rr       <= 1'b0;
         r_dect_out <= 1'b0;
         r_ch_idx   <= '0;
         r_cnt      <= '0;
         r_state    <= S_IDLE;
      end else begin
         r_sync1    <= dect_in;
         r_sync2    <= r_sync1;
         r_en       <= r_en ^ en_pulse;
         r_rr       <= r_rr ^ mode_pulse;
         r_dect_out <= w_qual;
         r_cnt      <= w_cnt_next;
         r_state    <= w_next;
         if (w_wrap && r_rr) begin
            if (r_ch_idx == CH_W'(N_CH - 1)) r_ch_idx <= '0;
            else                             r_ch_idx <= r_ch_idx + CH_W'(1);
         end
      end
   end

   // The wave is started from the next state so its first high cycle lines
   // up with the first registered MOD cycle.
   assign w_run = (w_next == S_MOD);

   bs_sqwave #(
      .HALF_PER (HALF_PER)
   ) u_sqwave (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (w_run),
      .sq    (w_sq)
   );

   assign dect_out  = r_dect_out;
   assign en        = r_en;
   assign busy      = (r_state != S_IDLE);
   assign ch_idx    = r_ch_idx;
   assign asw_sel   = (r_state == S_MOD) ? (N_CH'(1) << r_ch_idx) : '0;
   assign rfsw_a    = w_sq;
   assign rfsw_b    = ~w_sq;
   assign dbg_state = r_state;

endmodule
